mandel_engine_scheduler: RTL and testbench
==========================================

Name: mandel_engine_scheduler

Overview:
Frame-level scheduler that shares N_ENGINES depth-calculator engines across one Mandelbrot frame. It issues pixel coordinates in raster order to idle engines and captures each engine's colour result with its coordinates. A round-robin arbiter merges the results into one valid/ready pixel stream for the framebuffer writer. The block sits between the frame-control logic (start, width, height) and the engine array; coordinate-to-complex mapping stays inside each engine slice.

Parameters:
N_ENGINES, 4, number of depth-calculator engines (1..16)
COORD_W, 11, width of the x/y counters
COLOR_W, 24, width of the RGB result

Ports:
sysclk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  single-cycle request to render a frame
cfg_width  in  COORD_W  screen width in pixels, latched on an accepted frame_start
cfg_height  in  COORD_W  screen height in pixels, latched on an accepted frame_start
busy  out  1  high from an accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse when the last pixel of the frame has been accepted downstream
eng_start  out  N_ENGINES  one-hot, one-cycle dispatch pulse
eng_x  out  COORD_W  dispatch x, shared bus, valid with eng_start
eng_y  out  COORD_W  dispatch y, shared bus, valid with eng_start
eng_done  in  N_ENGINES  per-engine one-cycle result pulse
eng_color  in  N_ENGINES*COLOR_W  per-engine colour, valid with the matching eng_done bit
pix_valid  out  1  result stream valid
pix_ready  in  1  result stream ready
pix_x  out  COORD_W  result x
pix_y  out  COORD_W  result y
pix_color  out  COLOR_W  result colour

Behaviour:
- Reset (async assert, sync release): state IDLE. busy, frame_done, eng_start, pix_valid = 0. eng_x, eng_y, pix_x, pix_y, pix_color = 0. All slots free.
- Per-engine slot register holds {x, y, color, state}. Slot state is FREE, BUSY (dispatched) or FULL (result held).
- Registered FSM with states IDLE, RUN and FLUSH.
- IDLE: when frame_start=1, latch cfg_width and cfg_height, set busy=1 and go to RUN.
  - If the latched width or height is 0, go to FLUSH instead. frame_done then pulses on the cycle after FLUSH is entered and no dispatch occurs.
- RUN dispatch: at most one dispatch per cycle, to the lowest-index FREE slot.
  - The dispatch drives eng_start one-hot, eng_x/eng_y = current counter, and records x/y in the slot. The slot goes to BUSY.
  - x increments each dispatch; x wraps to 0 at width-1 and y increments.
  - The first eng_start occurs 1 cycle after the accepted frame_start.
  - After the dispatch of (width-1, height-1), go to FLUSH.
- eng_done[i] while slot i is BUSY: capture eng_color[i] and set the slot to FULL. eng_done to a FREE or FULL slot is ignored.
- Output arbiter: round-robin over FULL slots, starting after the last granted index.
  - The pix_* outputs are registered and held stable while pix_valid && !pix_ready.
  - On a handshake the granted slot becomes FREE. It is dispatchable the following cycle, not the same cycle.
  - The arbiter can load a new result on the handshake cycle, giving 1 pixel/cycle peak throughput.
- Accepted-pixel counter is 2*COORD_W bits wide and is compared against width*height, computed at latch time.
- FLUSH: when the counter reaches width*height and all slots are FREE, pulse frame_done for one cycle, drop busy and return to IDLE.
- frame_start outside IDLE is ignored. frame_start in the same cycle as frame_done is ignored; a new frame needs a start from IDLE.
- Simultaneous events in one cycle are all legal: eng_done on one slot, a handshake on another, and a dispatch to a third.
- Reset mid-frame aborts immediately with no frame_done. The engines must share reset_n.
- Ordering: results arrive out of raster order. Every (x, y) in the frame appears exactly once on the pix stream.

Decomposition:
- Shared package mandel_pkg holds:
  - COORD_W and COLOR_W constants
  - slot_state_t enum (FREE, BUSY, FULL)
  - sched_state_t enum (IDLE, RUN, FLUSH)
  - pixel_t struct {x, y, color}
- Sub-module rr_arbiter (parameter N; inputs req, advance; output one-hot grant) is instantiated once for the output merge.

Test Plan:
- 4x2 frame, N_ENGINES=4, pix_ready=1, engines reply in a fixed 3 cycles -> 8 distinct (x, y) on pix. First eng_start is 1 cycle after frame_start with eng_x=0, eng_y=0. frame_done pulses once and busy falls with it.
- cfg_width=0, cfg_height=5 -> no eng_start, no pix_valid. frame_done 2 cycles after frame_start.
- 3x3 frame, engine latencies 7/1/4/2 and pix_ready toggling 1010 -> pix_* stable while stalled. All 9 pixels delivered exactly once, out of raster order. Only FREE slots receive eng_start.
- Hold pix_ready=0 with 4 results FULL -> no further eng_start. Release pix_ready -> round-robin grant order 0,1,2,3. A slot is redispatched 1 cycle after its handshake.
- Spurious eng_done[2] while slot 2 FREE -> ignored, pixel count unchanged.
- Assert reset_n=0 mid-frame (after 5 dispatches of 640x480) -> all outputs 0 asynchronously. A fresh 2x2 frame then completes normally.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types and default widths for the Mandelbrot frame scheduler slice.
package mandel_pkg;

   localparam int COORD_W = 11;
   localparam int COLOR_W = 24;

   typedef enum logic [1:0] {FREE, BUSY, FULL} slot_state_t;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

endpackage

// File: rtl/mandel_engine_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last granted index.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         sysclk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last_q;
   logic [PW-1:0] grant_idx;
   int            idx;

   // Scan from farthest to nearest offset so the nearest requester after last_q wins.
   always_comb begin
      grant     = '0;
      grant_idx = last_q;
      idx       = 0;
      for (int i = N; i >= 1; i--) begin
         idx = (int'(last_q) + i) % N;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= PW'(N - 1);
      end else if (advance && |req) begin
         last_q <= grant_idx;
      end
   end

endmodule

// File: rtl/mandel_engine_scheduler.sv
// Frame scheduler: raster-order dispatch to shared depth engines, per-engine result slots,
// and a round-robin merge of finished slots into one valid/ready pixel stream.
module mandel_engine_scheduler #(
   parameter int N_ENGINES = 4,
   parameter int COORD_W   = 11,
   parameter int COLOR_W   = 24
) (
   input  logic                         sysclk,
   input  logic                         reset_n,
   input  logic                         frame_start,
   input  logic [COORD_W-1:0]           cfg_width,
   input  logic [COORD_W-1:0]           cfg_height,
   output logic                         busy,
   output logic                         frame_done,
   output logic [N_ENGINES-1:0]         eng_start,
   output logic [COORD_W-1:0]           eng_x,
   output logic [COORD_W-1:0]           eng_y,
   input  logic [N_ENGINES-1:0]         eng_done,
   input  logic [N_ENGINES*COLOR_W-1:0] eng_color,
   output logic                         pix_valid,
   input  logic                         pix_ready,
   output logic [COORD_W-1:0]           pix_x,
   output logic [COORD_W-1:0]           pix_y,
   output logic [COLOR_W-1:0]           pix_color
);

   import mandel_pkg::*;

   localparam int PC_W = 2 * COORD_W;
   localparam int IW   = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

   sched_state_t         state_q, state_d;
   slot_state_t          slot_state [N_ENGINES];
   logic [COORD_W-1:0]   slot_x     [N_ENGINES];
   logic [COORD_W-1:0]   slot_y     [N_ENGINES];
   logic [COLOR_W-1:0]   slot_color [N_ENGINES];

   logic [COORD_W-1:0]   x_cnt, y_cnt, width_q, height_q;
   logic [PC_W-1:0]      total_q, pix_cnt;
   logic [N_ENGINES-1:0] full_vec, held_q, req, grant;
   logic [IW-1:0]        free_idx, grant_sel;
   logic                 any_free, all_free;
   logic                 accept, dispatch, last_dispatch, handshake, load, flush_done;

   always_comb begin
      any_free  = 1'b0;
      all_free  = 1'b1;
      free_idx  = '0;
      grant_sel = '0;
      full_vec  = '0;
      for (int i = N_ENGINES - 1; i >= 0; i--) begin
         if (slot_state[i] == FREE) begin
            any_free = 1'b1;
            free_idx = IW'(i);
         end else begin
            all_free = 1'b0;
         end
         full_vec[i] = (slot_state[i] == FULL);
         if (grant[i]) grant_sel = IW'(i);
      end
   end

   // A frame_start landing on the frame_done cycle is dropped; a new frame must start from IDLE.
   assign accept        = (state_q == IDLE) && frame_start && !frame_done;
   assign dispatch      = (state_q == RUN) && any_free;
   assign last_dispatch = dispatch && (x_cnt == width_q - 1'b1) && (y_cnt == height_q - 1'b1);
   assign handshake     = pix_valid && pix_ready;
   assign load          = !pix_valid || pix_ready;
   assign flush_done    = (state_q == FLUSH) && (pix_cnt == total_q) && all_free;
   assign req           = full_vec & ~(pix_valid ? held_q : '0);
   assign busy          = (state_q != IDLE);
   assign eng_x         = x_cnt;
   assign eng_y         = y_cnt;

   rr_arbiter #(.N(N_ENGINES)) u_arb (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .req     (req),
      .advance (load),
      .grant   (grant)
   );

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      eng_start = '0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = (cfg_width == '0 || cfg_height == '0) ? FLUSH : RUN;
         end
         RUN: begin
            if (dispatch)      eng_start[free_idx] = 1'b1;
            if (last_dispatch) state_d = FLUSH;
         end
         FLUSH: begin
            if (flush_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         width_q    <= '0;
         height_q   <= '0;
         total_q    <= '0;
         pix_cnt    <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= flush_done;
         if (accept) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            total_q  <= PC_W'(cfg_width) * PC_W'(cfg_height);
            pix_cnt  <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
         end else begin
            if (dispatch) begin
               if (x_cnt == width_q - 1'b1) begin
                  x_cnt <= '0;
                  y_cnt <= y_cnt + 1'b1;
               end else begin
                  x_cnt <= x_cnt + 1'b1;
               end
            end
            if (handshake) pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end

   // Dispatch, capture and release touch a slot only in FREE, BUSY and FULL respectively.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_ENGINES; i++) begin
            slot_state[i] <= FREE;
            slot_x[i]     <= '0;
            slot_y[i]     <= '0;
            slot_color[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_ENGINES; i++) begin
            if (dispatch && free_idx == IW'(i)) begin
               slot_state[i] <= BUSY;
               slot_x[i]     <= x_cnt;
               slot_y[i]     <= y_cnt;
            end else if (slot_state[i] == BUSY && eng_done[i]) begin
               slot_state[i] <= FULL;
               slot_color[i] <= eng_color[i*COLOR_W +: COLOR_W];
            end else if (handshake && held_q[i]) begin
               slot_state[i] <= FREE;
            end
         end
      end
   end

   // The slot on the output stays FULL until its handshake; it is masked from the arbiter meanwhile.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_color <= '0;
         held_q    <= '0;
      end else if (load) begin
         if (|req) begin
            pix_valid <= 1'b1;
            pix_x     <= slot_x[grant_sel];
            pix_y     <= slot_y[grant_sel];
            pix_color <= slot_color[grant_sel];
            held_q    <= grant;
         end else begin
            pix_valid <= 1'b0;
            held_q    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// Directed bench: table of whole-frame vectors plus hand sequences for stall/round-robin and mid-frame reset.
module tb_mandel_engine_scheduler;

   import mandel_pkg::*;

   localparam int NE = 4;

   typedef struct {
      int         w;
      int         h;
      logic [15:0] lat;
      logic [3:0]  ready;
      logic [3:0]  spur;
      int         exp_pixels;
      int         exp_starts;
      int         exp_done_delay;
      bit         exp_ooo;
   } frame_vec_t;

   logic                    sysclk;
   logic                    reset_n;
   logic                    frame_start;
   logic [COORD_W-1:0]      cfg_width, cfg_height;
   logic                    busy, frame_done;
   logic [NE-1:0]           eng_start;
   logic [COORD_W-1:0]      eng_x, eng_y;
   logic [NE-1:0]           eng_done;
   logic [NE*COLOR_W-1:0]   eng_color;
   logic                    pix_valid, pix_ready;
   logic [COORD_W-1:0]      pix_x, pix_y;
   logic [COLOR_W-1:0]      pix_color;

   int vec_count   = 0;
   int miscompares = 0;
   int cyc         = 0;

   int               cnt [NE];
   int               lat [NE];
   logic [COORD_W-1:0] ex [NE];
   logic [COORD_W-1:0] ey [NE];
   bit               owned [NE];
   bit               hs_pend [NE];
   int               hs_cyc [NE];
   int               seen [int];
   int               grant_log [$];
   logic [3:0]       ready_pat;
   logic [3:0]       spur_mask;
   int               ready_phase, spur_cyc;
   int               pixels, starts, done_count, done_cyc, issue_cyc, pv_cycles;
   int               first_start_cyc, last_idx, cur_w, cur_h, redisp_n;
   logic [COORD_W-1:0] first_x, first_y;
   bit               ooo, chk_redisp, prev_stall, prev_busy;
   logic [2*COORD_W+COLOR_W-1:0] held_word;

   mandel_engine_scheduler #(.N_ENGINES(NE), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
      .sysclk      (sysclk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .cfg_width   (cfg_width),
      .cfg_height  (cfg_height),
      .busy        (busy),
      .frame_done  (frame_done),
      .eng_start   (eng_start),
      .eng_x       (eng_x),
      .eng_y       (eng_y),
      .eng_done    (eng_done),
      .eng_color   (eng_color),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_color   (pix_color)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic clearScoreboard();
      seen.delete();
      grant_log.delete();
      pixels = 0; starts = 0; done_count = 0; done_cyc = -1; pv_cycles = 0;
      first_start_cyc = -1; last_idx = -1; ooo = 0; redisp_n = 0; spur_cyc = -1;
      ready_phase = 0;
      for (int i = 0; i < NE; i++) begin
         owned[i] = 0;
         hs_pend[i] = 0;
      end
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      repeat (2) @(negedge sysclk);
      reset_n = 1'b1;
   endtask

   task automatic startFrame(input int w, input int h);
      cur_w = w;
      cur_h = h;
      @(negedge sysclk);
      issue_cyc   = cyc;
      frame_start = 1'b1;
      cfg_width   = COORD_W'(w);
      cfg_height  = COORD_W'(h);
      @(negedge sysclk);
      frame_start = 1'b0;
   endtask

   task automatic waitDone(input int budget, output bit timed_out);
      int n = 0;
      while (done_count == 0 && n < budget) begin
         @(negedge sysclk);
         n++;
      end
      timed_out = (done_count == 0);
      repeat (4) @(negedge sysclk);
   endtask

   task automatic applyStimulus(input frame_vec_t v, output bit timed_out);
      clearScoreboard();
      for (int i = 0; i < NE; i++) lat[i] = int'(v.lat[i*4 +: 4]);
      ready_pat = v.ready;
      spur_mask = v.spur;
      startFrame(v.w, v.h);
      spur_cyc = issue_cyc + 3;
      waitDone(3000, timed_out);
   endtask

   // Engine array and stream monitor, evaluated once per falling edge.
   initial begin
      int key, ridx, found;
      eng_done  = '0;
      eng_color = '0;
      pix_ready = 1'b1;
      for (int i = 0; i < NE; i++) cnt[i] = 0;
      forever begin
         @(negedge sysclk);
         pix_ready   = ready_pat[ready_phase];
         ready_phase = (ready_phase + 1) % 4;
         if (!reset_n) begin
            for (int i = 0; i < NE; i++) cnt[i] = 0;
            eng_done   = '0;
            prev_stall = 0;
            prev_busy  = 0;
            continue;
         end
         if (prev_stall) begin
            checkOutput("stall_valid", pix_valid, 1);
            checkOutput("stall_hold", {pix_x, pix_y, pix_color}, held_word);
         end
         prev_stall = pix_valid && !pix_ready;
         held_word  = {pix_x, pix_y, pix_color};
         if (pix_valid) pv_cycles++;
         if (pix_valid && pix_ready) begin
            key  = int'(pix_y) * 4096 + int'(pix_x);
            ridx = int'(pix_y) * cur_w + int'(pix_x);
            checkOutput("pix_in_frame", (int'(pix_x) < cur_w) && (int'(pix_y) < cur_h), 1);
            checkOutput("pix_unique", seen.exists(key), 0);
            seen[key] = 1;
            checkOutput("pix_color", pix_color, {pix_x, pix_y, 2'b01});
            if (ridx < last_idx) ooo = 1;
            last_idx = ridx;
            found = -1;
            for (int i = 0; i < NE; i++)
               if (owned[i] && ex[i] == pix_x && ey[i] == pix_y) found = i;
            checkOutput("pix_owner", found >= 0, 1);
            if (found >= 0) begin
               owned[found]   = 0;
               hs_cyc[found]  = cyc;
               hs_pend[found] = 1;
               grant_log.push_back(found);
            end
            pixels++;
         end
         if (frame_done) begin
            done_count++;
            done_cyc = cyc;
            checkOutput("busy_fall", {prev_busy, busy}, 2'b10);
         end
         prev_busy = busy;
         if (eng_start != '0) begin
            checkOutput("start_onehot", $onehot(eng_start), 1);
            if (starts == 0) begin
               first_start_cyc = cyc;
               first_x = eng_x;
               first_y = eng_y;
            end
            starts++;
         end
         eng_done = '0;
         for (int i = 0; i < NE; i++) begin
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  eng_done[i] = 1'b1;
                  eng_color[i*COLOR_W +: COLOR_W] = {ex[i], ey[i], 2'b01};
               end
            end
         end
         for (int i = 0; i < NE; i++) begin
            if (eng_start[i]) begin
               checkOutput("start_free_only", owned[i], 0);
               if (chk_redisp && hs_pend[i] && redisp_n < NE) begin
                  checkOutput("redispatch_delay", cyc - hs_cyc[i], 1);
                  redisp_n++;
               end
               hs_pend[i] = 0;
               owned[i] = 1;
               ex[i] = eng_x;
               ey[i] = eng_y;
               cnt[i] = lat[i];
            end
         end
         if (cyc == spur_cyc) begin
            for (int i = 0; i < NE; i++) begin
               if (spur_mask[i]) begin
                  eng_done[i] = 1'b1;
                  eng_color[i*COLOR_W +: COLOR_W] = 24'hABCDEF;
               end
            end
         end
      end
   end

   initial begin
      frame_vec_t vecs [6];
      frame_vec_t v22;
      bit to;
      int n;

      // w, h, latencies (engine 0 in low nibble), ready pattern (LSB first), spurious done mask,
      // expected pixels, expected dispatches, frame_done delay from frame_start (-1 unchecked), out-of-order expected
      vecs[0] = '{4, 2, 16'h3333, 4'b1111, 4'b0000, 8, 8, -1, 1'b0};
      vecs[1] = '{0, 5, 16'h3333, 4'b1111, 4'b0000, 0, 0,  2, 1'b0};
      vecs[2] = '{3, 3, 16'h2417, 4'b0101, 4'b0000, 9, 9, -1, 1'b1};
      vecs[3] = '{2, 1, 16'h5555, 4'b1111, 4'b0100, 2, 2, -1, 1'b0};
      vecs[4] = '{1, 1, 16'h1111, 4'b1111, 4'b0000, 1, 1, -1, 1'b0};
      vecs[5] = '{5, 0, 16'h1111, 4'b1111, 4'b0000, 0, 0,  2, 1'b0};
      v22     = '{2, 2, 16'h2213, 4'b1111, 4'b0000, 4, 4, -1, 1'b0};

      frame_start = 1'b0;
      cfg_width   = '0;
      cfg_height  = '0;
      ready_pat   = 4'b1111;
      spur_mask   = 4'b0000;
      chk_redisp  = 0;
      cur_w = 0;
      cur_h = 0;
      for (int i = 0; i < NE; i++) lat[i] = 1;
      clearScoreboard();
      reset_n = 1'b0;
      repeat (2) @(negedge sysclk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_eng_start", eng_start, 0);
      checkOutput("rst_pix_valid", pix_valid, 0);
      checkOutput("rst_eng_xy", {eng_x, eng_y}, 0);
      checkOutput("rst_pix_xyc", {pix_x, pix_y, pix_color}, 0);
      reset_n = 1'b1;

      for (int k = 0; k < 6; k++) begin
         applyStimulus(vecs[k], to);
         checkOutput($sformatf("v%0d_timeout", k), to, 0);
         checkOutput($sformatf("v%0d_pixels", k), pixels, vecs[k].exp_pixels);
         checkOutput($sformatf("v%0d_starts", k), starts, vecs[k].exp_starts);
         checkOutput($sformatf("v%0d_done_once", k), done_count, 1);
         checkOutput($sformatf("v%0d_busy_after", k), busy, 0);
         if (vecs[k].exp_starts > 0) begin
            checkOutput($sformatf("v%0d_first_delay", k), first_start_cyc - issue_cyc, 1);
            checkOutput($sformatf("v%0d_first_xy", k), {first_x, first_y}, 0);
         end else begin
            checkOutput($sformatf("v%0d_no_pix_valid", k), pv_cycles, 0);
         end
         if (vecs[k].exp_done_delay >= 0)
            checkOutput($sformatf("v%0d_done_delay", k), done_cyc - issue_cyc, vecs[k].exp_done_delay);
         if (vecs[k].exp_ooo)
            checkOutput($sformatf("v%0d_out_of_order", k), ooo, 1);
      end

      // Stall with every slot FULL, then release and watch the grant order and redispatch latency.
      doReset();
      clearScoreboard();
      for (int i = 0; i < NE; i++) lat[i] = 2;
      ready_pat  = 4'b0000;
      spur_mask  = 4'b0000;
      chk_redisp = 1;
      startFrame(4, 3);
      repeat (20) @(negedge sysclk);
      checkOutput("stall_starts", starts, 4);
      checkOutput("stall_pix_valid", pix_valid, 1);
      checkOutput("stall_pixels", pixels, 0);
      ready_pat = 4'b1111;
      waitDone(2000, to);
      chk_redisp = 0;
      checkOutput("rr_timeout", to, 0);
      checkOutput("rr_pixels", pixels, 12);
      checkOutput("rr_redispatch_count", redisp_n, 4);
      checkOutput("rr_log_len", grant_log.size() >= 4, 1);
      for (int k = 0; k < 4; k++) checkOutput($sformatf("rr_grant%0d", k), grant_log[k], k);

      // Abort a large frame mid-way, then run a fresh small frame.
      clearScoreboard();
      for (int i = 0; i < NE; i++) lat[i] = 2;
      ready_pat = 4'b1111;
      startFrame(640, 480);
      n = 0;
      while (starts < 5 && n < 200) begin
         @(negedge sysclk);
         n++;
      end
      checkOutput("abort_reached_5", starts >= 5, 1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_frame_done", frame_done, 0);
      checkOutput("abort_eng_start", eng_start, 0);
      checkOutput("abort_pix_valid", pix_valid, 0);
      checkOutput("abort_eng_xy", {eng_x, eng_y}, 0);
      checkOutput("abort_pix_xyc", {pix_x, pix_y, pix_color}, 0);
      checkOutput("abort_no_done", done_count, 0);
      repeat (2) @(negedge sysclk);
      reset_n = 1'b1;
      applyStimulus(v22, to);
      checkOutput("post_abort_timeout", to, 0);
      checkOutput("post_abort_pixels", pixels, 4);
      checkOutput("post_abort_done_once", done_count, 1);
      checkOutput("post_abort_first_delay", first_start_cyc - issue_cyc, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
